// File: rtl/abs_diff_sweep_pkg.sv
// Shared widths, FSM state encoding and the |x-y| helper for the abs-diff sweep controller.
package abs_diff_sweep_pkg;

   localparam int VEC_W = 8;
   localparam int RES_W = 4;
   localparam int CNT_W = 9;
   localparam int SUM_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_e;

   function automatic logic [RES_W-1:0] abs_sub(input logic [RES_W-1:0] x,
                                                input logic [RES_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/abs_diff_sweep_ctrl_if.sv
// Bus between the sweep controller (master) and its environment (slave).
// Extra first-fail signals appear only when ABS_DIFF_SWEEP_FIRST_FAIL_EN is defined.
interface abs_diff_sweep_ctrl_if;
   import abs_diff_sweep_pkg::*;

   // vec_vld qualifies vec_o for exactly one cycle; there is no backpressure, and
   // the approximate unit must present po_i exactly DUT_LAT cycles after that cycle.
   logic               start;
   logic               abort;
   logic [VEC_W-1:0]   vec_o;
   logic               vec_vld;
   logic [RES_W-1:0]   po_i;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   err_cnt;
   logic [RES_W-1:0]   max_err;
   logic [SUM_W-1:0]   sum_err;
   sweep_state_e       state;
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
   logic               ff_vld;
   logic [VEC_W-1:0]   ff_vec;
   logic [RES_W-1:0]   ff_exp;
   logic [RES_W-1:0]   ff_got;

   modport master (input  start, abort, po_i,
                   output vec_o, vec_vld, busy, done, err_cnt, max_err, sum_err, state,
                          ff_vld, ff_vec, ff_exp, ff_got);
   modport slave  (output start, abort, po_i,
                   input  vec_o, vec_vld, busy, done, err_cnt, max_err, sum_err, state,
                          ff_vld, ff_vec, ff_exp, ff_got);
`else
   modport master (input  start, abort, po_i,
                   output vec_o, vec_vld, busy, done, err_cnt, max_err, sum_err, state);
   modport slave  (output start, abort, po_i,
                   input  vec_o, vec_vld, busy, done, err_cnt, max_err, sum_err, state);
`endif

endinterface

// File: rtl/abs_diff_exact.sv
// Golden reference: combinational exact 4-bit unsigned |A-B|.
module abs_diff_exact
   import abs_diff_sweep_pkg::*;
(
   input  logic [RES_W-1:0] a_i,
   input  logic [RES_W-1:0] b_i,
   output logic [RES_W-1:0] diff_o
);

   assign diff_o = abs_sub(a_i, b_i);

endmodule

// File: rtl/abs_diff_sweep_ctrl.sv
// Drives all 256 operand pairs into an approximate |A-B| unit and scores its answers.
// Define ABS_DIFF_SWEEP_FIRST_FAIL_EN to also capture the first mismatching vector.
module abs_diff_sweep_ctrl
   import abs_diff_sweep_pkg::*;
#(
   parameter int DUT_LAT = 1  // legal range 1..4
) (
   input logic                   clk,
   input logic                   rst,
   abs_diff_sweep_ctrl_if.master bus
);

   sweep_state_e       state_q;
   logic [VEC_W-1:0]   vec_q;
   logic               vec_vld_q;
   logic               busy_q;
   logic               done_q;
   logic [1:0]         drain_q;

   logic [DUT_LAT-1:0] pipe_vld_q;
   logic [VEC_W-1:0]   pipe_vec_q [DUT_LAT];

   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [RES_W-1:0]   max_err_q, max_err_d;
   logic [SUM_W-1:0]   sum_err_q, sum_err_d;

   logic               start_acc;
   logic               abort_hit;
   logic               samp_vld;
   logic               samp_use;
   logic [VEC_W-1:0]   samp_vec;
   logic [RES_W-1:0]   exact;
   logic [RES_W-1:0]   err;

   assign start_acc = (state_q == ST_IDLE) && bus.start;
   assign abort_hit = bus.abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign samp_vld  = pipe_vld_q[DUT_LAT-1];
   assign samp_vec  = pipe_vec_q[DUT_LAT-1];
   // An abort discards the sample landing in the same cycle.
   assign samp_use  = samp_vld && !abort_hit;

   abs_diff_exact u_exact (
      .a_i    (samp_vec[RES_W-1:0]),
      .b_i    (samp_vec[VEC_W-1:RES_W]),
      .diff_o (exact)
   );

   assign err = abs_sub(exact, bus.po_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         vec_q     <= '0;
         vec_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         drain_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_acc) begin
                  state_q   <= ST_RUN;
                  vec_q     <= '0;
                  vec_vld_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ST_RUN: begin
               if (abort_hit) begin
                  state_q   <= ST_IDLE;
                  vec_vld_q <= 1'b0;
                  busy_q    <= 1'b0;
               end else if (vec_q == '1) begin
                  state_q   <= ST_DRAIN;
                  vec_vld_q <= 1'b0;
                  drain_q   <= '0;
               end else begin
                  vec_q <= vec_q + VEC_W'(1);
               end
            end
            ST_DRAIN: begin
               if (abort_hit) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (drain_q == 2'(DUT_LAT - 1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || abort_hit) begin
         pipe_vld_q <= '0;
      end else begin
         pipe_vld_q[0] <= vec_vld_q;
         for (int i = 1; i < DUT_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      pipe_vec_q[0] <= vec_q;
      for (int i = 1; i < DUT_LAT; i++) begin
         pipe_vec_q[i] <= pipe_vec_q[i-1];
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      max_err_d = max_err_q;
      sum_err_d = sum_err_q;
      if (start_acc) begin
         err_cnt_d = '0;
         max_err_d = '0;
         sum_err_d = '0;
      end else if (samp_use) begin
         err_cnt_d = err_cnt_q + CNT_W'(err != '0);
         sum_err_d = sum_err_q + SUM_W'(err);
         max_err_d = (err > max_err_q) ? err : max_err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
         max_err_q <= '0;
         sum_err_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         max_err_q <= max_err_d;
         sum_err_q <= sum_err_d;
      end
   end

`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
   logic               ff_vld_q, ff_vld_d;
   logic [VEC_W-1:0]   ff_vec_q, ff_vec_d;
   logic [RES_W-1:0]   ff_exp_q, ff_exp_d;
   logic [RES_W-1:0]   ff_got_q, ff_got_d;

   always_comb begin
      ff_vld_d = ff_vld_q;
      ff_vec_d = ff_vec_q;
      ff_exp_d = ff_exp_q;
      ff_got_d = ff_got_q;
      if (start_acc) begin
         ff_vld_d = 1'b0;
         ff_vec_d = '0;
         ff_exp_d = '0;
         ff_got_d = '0;
      end else if (samp_use && (err != '0) && !ff_vld_q) begin
         ff_vld_d = 1'b1;
         ff_vec_d = samp_vec;
         ff_exp_d = exact;
         ff_got_d = bus.po_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ff_vld_q <= 1'b0;
         ff_vec_q <= '0;
         ff_exp_q <= '0;
         ff_got_q <= '0;
      end else begin
         ff_vld_q <= ff_vld_d;
         ff_vec_q <= ff_vec_d;
         ff_exp_q <= ff_exp_d;
         ff_got_q <= ff_got_d;
      end
   end

   assign bus.ff_vld = ff_vld_q;
   assign bus.ff_vec = ff_vec_q;
   assign bus.ff_exp = ff_exp_q;
   assign bus.ff_got = ff_got_q;
`endif

   assign bus.vec_o   = vec_q;
   assign bus.vec_vld = vec_vld_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err_cnt = err_cnt_q;
   assign bus.max_err = max_err_q;
   assign bus.sum_err = sum_err_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_abs_diff_sweep_ctrl.sv
// Bench for abs_diff_sweep_ctrl: two instances (DUT_LAT=1 and 3) against a modelled
// approximate unit; also checks the first-fail outputs when ABS_DIFF_SWEEP_FIRST_FAIL_EN is set.
module tb_abs_diff_sweep_ctrl;
   import abs_diff_sweep_pkg::*;

   localparam int RW = CNT_W + RES_W + SUM_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   int   po_mode;

   always #5 clk = ~clk;

   abs_diff_sweep_ctrl_if if1 ();
   abs_diff_sweep_ctrl_if if3 ();

   abs_diff_sweep_ctrl #(.DUT_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
   abs_diff_sweep_ctrl #(.DUT_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.master));

   // ---------------- approximate unit model ----------------
   function automatic logic [3:0] ref_exact(input logic [7:0] v);
      logic [3:0] a;
      logic [3:0] b;
      a = v[3:0];
      b = v[7:4];
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [3:0] unit_model(input int mode, input logic [7:0] v);
      logic [3:0] ex;
      ex = ref_exact(v);
      case (mode)
         0:       return ex;
         1:       return 4'h0;
         2:       return ex ^ 4'h1;
         default: return (v[2:0] == 3'd5) ? (ex ^ 4'h6) : ((v[7:5] == 3'd7) ? 4'hF : ex);
      endcase
   endfunction

   logic [7:0] d1_q = '0;
   logic [7:0] d3_q [3] = '{default: '0};

   always @(posedge clk) begin
      d1_q    <= if1.vec_o;
      d3_q[0] <= if3.vec_o;
      d3_q[1] <= d3_q[0];
      d3_q[2] <= d3_q[1];
   end

   assign if1.po_i  = unit_model(po_mode, d1_q);
   assign if3.po_i  = unit_model(po_mode, d3_q[2]);
   assign if1.start = start;
   assign if3.start = start;
   assign if1.abort = abort;
   assign if3.abort = abort;

   // Expected {err_cnt, max_err, sum_err} over vectors 0..nvec-1.
   function automatic logic [RW-1:0] sweep_model(input int mode, input int nvec);
      int cnt = 0;
      int sum = 0;
      int mx  = 0;
      for (int v = 0; v < nvec; v++) begin
         int ex;
         int po;
         int e;
         ex = int'(ref_exact(8'(v)));
         po = int'(unit_model(mode, 8'(v)));
         e  = (ex > po) ? (ex - po) : (po - ex);
         if (e != 0) cnt++;
         sum += e;
         if (e > mx) mx = e;
      end
      return {CNT_W'(cnt), RES_W'(mx), SUM_W'(sum)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [RW-1:0] exp1_q[$];
   logic [RW-1:0] exp3_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] res1();
      return 32'({if1.err_cnt, if1.max_err, if1.sum_err});
   endfunction

   function automatic logic [31:0] res3();
      return 32'({if3.err_cnt, if3.max_err, if3.sum_err});
   endfunction

   // ---------------- driver tasks ----------------
   // One full sweep; poke_start also pulses start mid-run and on DUT1's DONE cycle.
   task automatic run_sweep(input int mode, input bit poke_start);
      int done1_at = -1;
      int done3_at = -1;
      int n_done1  = 0;
      int n_done3  = 0;
      int vec_ok   = 0;
      logic [RW-1:0] e;
      po_mode = mode;
      exp1_q.push_back(sweep_model(mode, 256));
      exp3_q.push_back(sweep_model(mode, 256));
      start = 1'b1;
      for (int cyc = 1; cyc <= 270; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke_start && (cyc == 50)) start = 1'b1;
         if (cyc == 1) check_eq("busy_run", 32'(if1.busy), 32'd1);
         if ((cyc <= 256) && if1.vec_vld && (if1.vec_o == 8'(cyc - 1))) vec_ok++;
         if (if1.done) begin
            n_done1++;
            if (n_done1 == 1) begin
               done1_at = cyc;
               check_eq("sb1_size", 32'(exp1_q.size()), 32'd1);
               if (exp1_q.size() > 0) begin
                  e = exp1_q.pop_front();
                  check_eq("res1", res1(), 32'(e));
               end
            end
            if (poke_start) start = 1'b1;
         end
         if (if3.done) begin
            n_done3++;
            if (n_done3 == 1) begin
               done3_at = cyc;
               check_eq("sb3_size", 32'(exp3_q.size()), 32'd1);
               if (exp3_q.size() > 0) begin
                  e = exp3_q.pop_front();
                  check_eq("res3", res3(), 32'(e));
               end
            end
         end
      end
      check_eq("vec_seq", 32'(vec_ok), 32'd256);
      check_eq("done1_cyc", 32'(done1_at), 32'(256 + 1 + 1));
      check_eq("done3_cyc", 32'(done3_at), 32'(256 + 3 + 1));
      check_eq("done1_cnt", 32'(n_done1), 32'd1);
      check_eq("done3_cnt", 32'(n_done3), 32'd1);
      check_eq("busy_after", 32'({if1.busy, if3.busy}), 32'd0);
      check_eq("state_after", 32'(if1.state), 32'(ST_IDLE));
      exp1_q.delete();
      exp3_q.delete();
   endtask

   task automatic run_abort(input int mode);
      int seen = 0;
      logic [RW-1:0] p1;
      logic [RW-1:0] p3;
      po_mode = mode;
      p1 = sweep_model(mode, 98);
      p3 = sweep_model(mode, 96);
      start = 1'b1;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 100) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_state", 32'(if1.state), 32'(ST_IDLE));
      check_eq("abort_vld", 32'({if1.vec_vld, if3.vec_vld}), 32'd0);
      check_eq("abort_busy", 32'({if1.busy, if3.busy}), 32'd0);
      check_eq("abort_part1", res1(), 32'(p1));
      check_eq("abort_part3", res3(), 32'(p3));
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (if1.done || if3.done) seen++;
      end
      check_eq("abort_no_done", 32'(seen), 32'd0);
      check_eq("abort_hold1", res1(), 32'(p1));
   endtask

   task automatic run_reset_mid(input int mode);
      int seen = 0;
      po_mode = mode;
      start = 1'b1;
      for (int cyc = 1; cyc <= 50; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 50) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check_eq("rstmid_out1", 32'({if1.vec_o, if1.vec_vld, if1.busy, if1.done}), 32'd0);
      check_eq("rstmid_res1", res1(), 32'd0);
      check_eq("rstmid_res3", res3(), 32'd0);
      check_eq("rstmid_busy3", 32'({if3.vec_vld, if3.busy}), 32'd0);
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (if1.done || if3.done) seen++;
      end
      check_eq("rstmid_no_done", 32'(seen), 32'd0);
      check_eq("rstmid_hold", res3(), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      po_mode = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_vec", 32'(if1.vec_o), 32'd0);
      check_eq("rst_ctl", 32'({if1.vec_vld, if1.busy, if1.done}), 32'd0);
      check_eq("rst_res1", res1(), 32'd0);
      check_eq("rst_res3", res3(), 32'd0);
      check_eq("rst_state", 32'(if1.state), 32'(ST_IDLE));
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
      check_eq("rst_ff_vld", 32'(if1.ff_vld), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      run_sweep(0, 1'b1);
      check_eq("exact_res1", res1(), 32'd0);
      check_eq("exact_res3", res3(), 32'd0);

      run_sweep(1, 1'b0);
      check_eq("zero_cnt", 32'(if1.err_cnt), 32'd240);
      check_eq("zero_max", 32'(if1.max_err), 32'd15);
      check_eq("zero_sum", 32'(if1.sum_err), 32'd1360);
      check_eq("zero_res3", res3(), 32'({9'd240, 4'd15, 12'd1360}));
`ifdef ABS_DIFF_SWEEP_FIRST_FAIL_EN
      check_eq("ff_vld", 32'(if1.ff_vld), 32'd1);
      check_eq("ff_vec", 32'(if1.ff_vec), 32'h01);
      check_eq("ff_exp", 32'(if1.ff_exp), 32'd1);
      check_eq("ff_got", 32'(if1.ff_got), 32'd0);
`endif

      run_sweep(2, 1'b0);
      check_eq("xor_cnt3", 32'(if3.err_cnt), 32'd256);
      check_eq("xor_max3", 32'(if3.max_err), 32'd1);
      check_eq("xor_sum3", 32'(if3.sum_err), 32'd256);
      check_eq("xor_res1", res1(), 32'({9'd256, 4'd1, 12'd256}));

      run_sweep(3, 1'b0);

      run_abort(1);
      run_sweep(2, 1'b0);

      run_reset_mid(3);
      run_sweep(0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
